// File: rtl/bbox_tracker.sv
// Bounding-box tracker for a binary pixel stream: accumulates min/max x/y and a set-pixel count
// over one frame and commits them, including the last pixel, one cycle after that pixel.
module bbox_tracker #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned MIN_COUNT = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Value,
    input  logic        Data_in,
    input  logic        Frame_start,
    output logic [9:0]  X_min,
    output logic [9:0]  X_max,
    output logic [9:0]  Y_min,
    output logic [9:0]  Y_max,
    output logic [18:0] Pix_count,
    output logic        Box_valid,
    output logic        Done,
    output logic        Frame_err
);

    localparam logic [9:0]  XLast   = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  YLast   = 10'(V_ACTIVE - 1);
    localparam logic [9:0]  MinInit = 10'h3FF;
    localparam logic [18:0] MinCnt  = 19'(MIN_COUNT);

    typedef enum logic {StWaitSof, StActive} state_e;

    state_e      state_q, state_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [9:0]  xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
    logic [18:0] cnt_q, cnt_d;
    logic [9:0]  oxmin_q, oxmin_d, oxmax_q, oxmax_d, oymin_q, oymin_d, oymax_q, oymax_d;
    logic [18:0] ocnt_q, ocnt_d;
    logic        ovalid_q, ovalid_d, done_q, done_d, err_q, err_d;

    logic        sof, take, abort, last, hit;
    logic [9:0]  px, py;
    logic [9:0]  bxmin, bxmax, bymin, bymax;
    logic [18:0] bcnt;
    logic [9:0]  mxmin, mxmax, mymin, mymax;
    logic [18:0] mcnt;

    // A qualified Frame_start always restarts at (0,0); in ACTIVE it is an abort,
    // even when it lands on the last pixel.
    assign sof   = Value & Frame_start;
    assign take  = Value & ((state_q == StActive) | Frame_start);
    assign abort = sof & (state_q == StActive);
    assign px    = sof ? 10'd0 : x_q;
    assign py    = sof ? 10'd0 : y_q;
    assign last  = take & ~abort & (px == XLast) & (py == YLast);
    assign hit   = take & Data_in;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StWaitSof;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (last) begin
            state_d = StWaitSof;
        end else if (sof) begin
            state_d = StActive;
        end
    end

    always_comb begin
        // Merge the current pixel into either the running or a freshly initialised accumulator.
        bxmin = sof ? MinInit : xmin_q;
        bxmax = sof ? 10'd0   : xmax_q;
        bymin = sof ? MinInit : ymin_q;
        bymax = sof ? 10'd0   : ymax_q;
        bcnt  = sof ? 19'd0   : cnt_q;
        mxmin = (hit && px < bxmin) ? px : bxmin;
        mxmax = (hit && px > bxmax) ? px : bxmax;
        mymin = (hit && py < bymin) ? py : bymin;
        mymax = (hit && py > bymax) ? py : bymax;
        mcnt  = bcnt + {18'd0, hit};

        x_d      = x_q;
        y_d      = y_q;
        xmin_d   = mxmin;
        xmax_d   = mxmax;
        ymin_d   = mymin;
        ymax_d   = mymax;
        cnt_d    = mcnt;
        oxmin_d  = oxmin_q;
        oxmax_d  = oxmax_q;
        oymin_d  = oymin_q;
        oymax_d  = oymax_q;
        ocnt_d   = ocnt_q;
        ovalid_d = ovalid_q;
        done_d   = last;
        err_d    = abort;

        if (take) begin
            if (px == XLast) begin
                x_d = 10'd0;
                y_d = py + 10'd1;
            end else begin
                x_d = px + 10'd1;
                y_d = py;
            end
        end

        if (last) begin
            x_d      = 10'd0;
            y_d      = 10'd0;
            xmin_d   = MinInit;
            xmax_d   = 10'd0;
            ymin_d   = MinInit;
            ymax_d   = 10'd0;
            cnt_d    = 19'd0;
            oxmin_d  = (mcnt == 19'd0) ? 10'd0 : mxmin;
            oxmax_d  = mxmax;
            oymin_d  = (mcnt == 19'd0) ? 10'd0 : mymin;
            oymax_d  = mymax;
            ocnt_d   = mcnt;
            ovalid_d = (mcnt >= MinCnt);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            x_q      <= 10'd0;
            y_q      <= 10'd0;
            xmin_q   <= MinInit;
            xmax_q   <= 10'd0;
            ymin_q   <= MinInit;
            ymax_q   <= 10'd0;
            cnt_q    <= 19'd0;
            oxmin_q  <= 10'd0;
            oxmax_q  <= 10'd0;
            oymin_q  <= 10'd0;
            oymax_q  <= 10'd0;
            ocnt_q   <= 19'd0;
            ovalid_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            xmin_q   <= xmin_d;
            xmax_q   <= xmax_d;
            ymin_q   <= ymin_d;
            ymax_q   <= ymax_d;
            cnt_q    <= cnt_d;
            oxmin_q  <= oxmin_d;
            oxmax_q  <= oxmax_d;
            oymin_q  <= oymin_d;
            oymax_q  <= oymax_d;
            ocnt_q   <= ocnt_d;
            ovalid_q <= ovalid_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign X_min     = oxmin_q;
    assign X_max     = oxmax_q;
    assign Y_min     = oymin_q;
    assign Y_max     = oymax_q;
    assign Pix_count = ocnt_q;
    assign Box_valid = ovalid_q;
    assign Done      = done_q;
    assign Frame_err = err_q;

endmodule
